// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Entries narrow as they age: WB only needs what makes it a forwarding source.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [3:0] dst;
  } wr_info_t;

  typedef struct packed {
    wr_info_t w;
    logic     load;
  } stage_t;

  // Source fields exist only while the instruction sits in EX.
  typedef struct packed {
    stage_t     s;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       use1;
    logic       use2;
  } sb_entry_t;

  function automatic logic is_writer(wr_info_t w);
    return w.valid && w.wr && (w.dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX operand: MEM beats WB, and loads in MEM
// never forward because their data is not ready yet.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic       use_src,
  input  logic [3:0] src,
  input  stage_t     mem,
  input  wr_info_t   wb,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (use_src && is_writer(mem.w) && !mem.load && (mem.w.dst == src)) begin
      sel = FWD_MEM;
    end else if (use_src && is_writer(wb) && (wb.dst == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX/MEM/WB scoreboard, load-use stall, branch flush,
// EX forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [3:0]       id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  sb_entry_t ex_q;
  sb_entry_t ex_d;
  stage_t    mem_q;
  wr_info_t  wb_q;
  logic      load_use;

  assign load_use = id_valid && is_writer(ex_q.s.w) && ex_q.s.load &&
                    ((id_use1 && (id_src1 == ex_q.s.w.dst)) ||
                     (id_use2 && (id_src2 == ex_q.s.w.dst)));

  // rst gating keeps the outputs quiet while reset is held, whatever the inputs do.
  always_comb begin
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (rst) begin
      if (mem_busy) begin
        stall_id = 1'b1;
      end else if (br_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  always_comb begin
    ex_d = '0;
    if (id_valid && !bubble_ex) begin
      ex_d.s.w.valid = 1'b1;
      ex_d.s.w.wr    = id_wr;
      ex_d.s.w.dst   = id_dst;
      ex_d.s.load    = id_load;
      ex_d.src1      = id_src1;
      ex_d.src2      = id_src2;
      ex_d.use1      = id_use1;
      ex_d.use2      = id_use2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_busy) begin
      wb_q  <= mem_q.w;
      mem_q <= ex_q.s;
      ex_q  <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_id && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  fwd_sel u_fwd_a (
    .use_src (ex_q.s.w.valid && ex_q.use1),
    .src     (ex_q.src1),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (fwd_a)
  );

  fwd_sel u_fwd_b (
    .use_src (ex_q.s.w.valid && ex_q.use2),
    .src     (ex_q.src2),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (fwd_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: scenario tasks push expected outputs into a queue
// as they drive decode/branch/memory stimulus and pop them at the sample point.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use1, id_use2, id_wr, id_load, br_taken, mem_busy;
  logic [3:0]  id_src1, id_src2, id_dst;
  logic        stall_id, bubble_ex, flush_id;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic        stall_id_s, bubble_ex_s, flush_id_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [3:0]  stall_cnt_sat;
  logic [6:0]  ctl;

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = '0;
  logic [3:0]  sat_exp = '0;

  always #5 clk = ~clk;

  assign ctl = {stall_id, bubble_ex, flush_id, fwd_a, fwd_b};

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
    .br_taken(br_taken), .mem_busy(mem_busy), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
    .br_taken(br_taken), .mem_busy(mem_busy), .stall_id(stall_id_s), .bubble_ex(bubble_ex_s),
    .flush_id(flush_id_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_sat)
  );

  task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2, input logic [3:0] d,
                        input logic w, input logic ld);
    id_valid = v; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
    id_dst = d; id_wr = w; id_load = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    br_taken = 0;
    mem_busy = 0;
    repeat (3) next_cycle();
  endtask

  task automatic test_reset();
    rst = 0; br_taken = 1; mem_busy = 1;
    set_id(1, 3, 1, 3, 1, 3, 1, 1);
    exp_q.push_back('{"reset_outputs", 7'b0000000, 16'd0});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    br_taken = 0; mem_busy = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1;
    next_cycle();
  endtask

  task automatic test_load_use();
    set_id(1, 1, 0, 0, 0, 3, 1, 1);
    exp_q.push_back('{"lu_lw_decode", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle();
    set_id(1, 3, 1, 5, 1, 4, 1, 0);
    exp_q.push_back('{"lu_stall", 7'b1100000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle(); exp_cnt++;
    exp_q.push_back('{"lu_stall_drops", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back('{"lu_fwd_a_wb", 7'b0001000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    drain();
  endtask

  task automatic test_mem_priority();
    set_id(1, 0, 0, 0, 0, 2, 1, 0);
    next_cycle();
    set_id(1, 0, 0, 0, 0, 2, 1, 0);
    next_cycle();
    set_id(1, 7, 1, 2, 1, 9, 1, 0);
    exp_q.push_back('{"mp_no_stall", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back('{"mp_fwd_b_mem", 7'b0000001, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    drain();
  endtask

  task automatic test_r0();
    set_id(1, 0, 0, 0, 0, 0, 1, 0);
    next_cycle();
    set_id(1, 0, 1, 0, 1, 0, 0, 0);
    exp_q.push_back('{"r0_decode", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back('{"r0_no_fwd", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle();
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    next_cycle();
    set_id(1, 0, 1, 0, 1, 5, 1, 0);
    exp_q.push_back('{"r0_lw_no_stall", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    drain();
  endtask

  task automatic test_branch_flush();
    set_id(1, 1, 0, 0, 0, 3, 1, 1);
    next_cycle();
    set_id(1, 3, 1, 0, 0, 4, 1, 0);
    br_taken = 1;
    exp_q.push_back('{"br_flush_wins", 7'b0110000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle();
    br_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back('{"br_ex_bubble", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    drain();
  endtask

  task automatic test_mem_busy();
    set_id(1, 1, 0, 0, 0, 3, 1, 1);
    next_cycle();
    set_id(1, 3, 1, 5, 0, 4, 1, 0);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{"mb_frozen", 7'b1000000, exp_cnt});
      #2 e = exp_q.pop_front(); n_tests++;
      if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
        n_fail++; $display("FAIL %s[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, i, ctl, stall_cnt, e.ctl, e.cnt);
      end
      next_cycle(); exp_cnt++;
    end
    mem_busy = 0;
    exp_q.push_back('{"mb_lu_stall", 7'b1100000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle(); exp_cnt++;
    exp_q.push_back('{"mb_release", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back('{"mb_fwd_a_wb", 7'b0001000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    drain();
  endtask

  task automatic test_async_reset();
    set_id(1, 1, 0, 0, 0, 3, 1, 1);
    next_cycle();
    set_id(1, 3, 1, 0, 0, 4, 1, 0);
    exp_q.push_back('{"ar_pre_stall", 7'b1100000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    #1 rst = 0;
    exp_cnt = '0; sat_exp = '0;
    exp_q.push_back('{"ar_immediate", 7'b0000000, exp_cnt});
    #1 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    @(posedge clk);
    #3 rst = 1;
    exp_q.push_back('{"ar_after_release", 7'b0000000, exp_cnt});
    #1 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    @(posedge clk);
    #1 drain();
  endtask

  task automatic test_saturate();
    mem_busy = 1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back('{"sat_small_cnt", 7'b1000000, {12'd0, sat_exp}});
      #2 e = exp_q.pop_front(); n_tests++;
      if ({stall_id_s, 6'd0, 12'd0, stall_cnt_sat} !== {e.ctl, e.cnt}) begin
        n_fail++; $display("FAIL %s[%0d]: got stall=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, i, stall_id_s, stall_cnt_sat, e.ctl, e.cnt);
      end
      next_cycle();
      exp_cnt++;
      if (sat_exp != 4'hF) sat_exp++;
    end
    mem_busy = 0;
    exp_q.push_back('{"sat_wide_cnt", 7'b0000000, exp_cnt});
    #2 e = exp_q.pop_front(); n_tests++;
    if ({ctl, stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++; $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", e.name, ctl, stall_cnt, e.ctl, e.cnt);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_priority();
    test_r0();
    test_branch_flush();
    test_mem_busy();
    test_async_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 16-bit five-stage CPU. Sits beside the decode stage and its register file. Tracks in-flight destination registers through EX, MEM and WB in a small scoreboard. Produces the load-use stall, the EX-stage forwarding selects, the branch flush controls, and a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- id_valid  in  1  decode holds a real instruction
- id_src1  in  4  decode source register 1 (instr[7:4])
- id_src2  in  4  decode source register 2 (already muxed by RegSrc)
- id_use1, id_use2  in  1  instruction actually reads src1 / src2
- id_dst  in  4  decode destination (instr[11:8])
- id_wr  in  1  instruction writes the register file
- id_load  in  1  instruction is LW
- br_taken  in  1  branch resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; whole pipeline frozen
- stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_id  out  1  squash IF/ID contents
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result
- stall_cnt  out  CNT_W  saturating count of cycles with stall_id high

## Operation
- Scoreboard: three entries EX, MEM, WB. Each holds valid, dst[3:0], load, src1[3:0], src2[3:0], use1, use2. Source fields are kept only in EX.
- An entry is a "writer" iff valid && wr && dst != 0. R0 is hardwired zero and never creates a hazard.
- Load-use: stall_id = bubble_ex = 1 when id_valid, the EX entry is a writer with load=1, and (id_use1 && id_src1==EX.dst) or (id_use2 && id_src2==EX.dst).
- No decode-vs-MEM/WB stall. EX-path forwarding covers MEM. The register file bypasses same-cycle WB writes to decode.
- Forwarding for the EX entry operand A (B is symmetric with src2/use2):
  - fwd_a = 01 if use1 and MEM is a non-load writer with dst==src1.
  - Otherwise 10 if use1 and WB is a writer with dst==src1.
  - Otherwise 00.
  - MEM has priority over WB. A load sitting in MEM never forwards; the load-use stall guarantees it is in WB by then.
- Branch: br_taken forces flush_id=1 and bubble_ex=1. The instruction in decode enters EX as invalid.
- Advance each cycle when mem_busy=0: WB<-MEM, MEM<-EX, EX<-decode fields. If bubble_ex, the new EX entry gets valid=0.
- mem_busy=1: all entries hold. stall_id=1. bubble_ex=0, flush_id=0. fwd_* stay computed from the held state.
- Priority on simultaneous events: mem_busy > br_taken > load-use.
- Load-use and br_taken in the same cycle: flush wins. stall_id=0, since the decode instruction is dead.
- stall_cnt increments on every cycle with stall_id=1 and saturates at all-ones.

## Timing
- stall_id, bubble_ex, flush_id and fwd_* are combinational from scoreboard state plus current inputs, valid in the same cycle.
- Scoreboard updates on the rising clk edge.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and the stall drops.
- Reset (rst low, asynchronous, any time including mid-stall):
  - all entries valid=0, stall_cnt=0;
  - outputs: stall_id=0, bubble_ex=0, flush_id=0, fwd_a=fwd_b=00.
- First advance happens on the first clk edge after rst deasserts.

## Structure
- Shared package hazard_pkg holds:
  - fwd encodings FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - the scoreboard entry struct;
  - the constant REG_ZERO=4'd0.
- One sub-module, fwd_sel: the combinational match/priority for one operand, instantiated twice.

## Test plan
- LW R3 in EX, decode ADD R4,R3,R5 (use1, src1=3) -> stall_id=1 and bubble_ex=1 for one cycle. Next cycle ADD in EX with fwd_a=10.
- ADD R2 in MEM and SUB R2 in WB; EX instruction reads R2 on B -> fwd_b=01 (MEM priority).
- Writer with dst=R0 in MEM; EX reads R0 -> fwd_a=00. LW R0 in EX with decode reading R0 -> no stall.
- br_taken=1 together with a load-use condition -> flush_id=1, bubble_ex=1, stall_id=0, stall_cnt unchanged.
- mem_busy=1 for 3 cycles during a load-use -> scoreboard frozen, stall_cnt +3. Release -> the single load-use stall then occurs, stall_cnt +1.
- Assert rst low mid-stall, asynchronous to clk -> outputs go to reset values immediately and stall_cnt=0. Preset stall_cnt near max -> it saturates at 0xFFFF.
